sr_reg_bank: RTL and testbench

SR_REG_BANK -- requirements
Module: sr_reg_bank

---
 rtl/sr_pkg.sv | 38 +++
 rtl/sr_reg_bank_if.sv | 32 +++
 rtl/sr_cell.sv | 64 ++++++
 rtl/sr_reg_bank.sv | 64 ++++++
 tb/tb_sr_reg_bank.sv | 124 ++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_pkg                                                      |
// | Brief  : Shared SR conflict-mode encodings and next-state helper.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package sr_pkg;

    typedef enum logic [1:0] {
        SET_DOM = 2'd0,
        RST_DOM = 2'd1,
        HOLD    = 2'd2,
        TOGGLE  = 2'd3
    } sr_mode_e;

    function automatic logic sr_next(input logic q, input logic s,
                                     input logic r, input sr_mode_e mode);
        logic nq;
        nq = q;
        case ({s, r})
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            2'b11: begin
                case (mode)
                    SET_DOM: nq = 1'b1;
                    RST_DOM: nq = 1'b0;
                    HOLD:    nq = q;
                    TOGGLE:  nq = ~q;
                    default: nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_reg_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_reg_bank_if                                              |
// | Brief  : Request/status bundle for the SR register bank.             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface sr_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] en;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] conflict;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output s, r, en, clr_err,
        input  q, q_bar, rise, fall, conflict, conflict_cnt
    );

    modport slave (
        input  s, r, en, clr_err,
        output q, q_bar, rise, fall, conflict, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_cell                                                     |
// | Brief  : One SR channel: state, edge pulses and sticky conflict bit. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module sr_cell
    import sr_pkg::*;
#(
    parameter sr_mode_e MODE      = SET_DOM,
    parameter bit       DIS_CLEAR = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic s,
    input  wire logic r,
    input  wire logic en,
    input  wire logic clr_err,
    output logic      q,
    output logic      rise,
    output logic      fall,
    output logic      conflict,
    output logic      hit
);

    logic r_q;
    logic r_rise;
    logic r_fall;
    logic r_conflict;
    logic w_next;

    assign hit = en & s & r;

    always_comb begin
        w_next = r_q;
        if (en) begin
            w_next = sr_next(r_q, s, r, MODE);
        end else if (DIS_CLEAR) begin
            w_next = 1'b0;
        end
    end

    // Edge pulses compare against the old state, so reset never emits a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_next;
            r_rise     <= ~r_q & w_next;
            r_fall     <= r_q & ~w_next;
            r_conflict <= hit | (r_conflict & ~clr_err);
        end
    end

    assign q        = r_q;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign conflict = r_conflict;

endmodule
`default_nettype wire

// File: rtl/sr_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_reg_bank                                                 |
// | Brief  : WIDTH-channel SR register bank with conflict tracking.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter bit DIS_CLEAR = 1'b0,
    parameter int CNT_W     = 8
) (
    input wire logic   clk,
    input wire logic   rst,
    sr_reg_bank_if.slave bus
);

    localparam sr_mode_e C_MODE = sr_mode_e'(MODE[1:0]);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_hit;
    logic             w_any_hit;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE      (C_MODE),
            .DIS_CLEAR (DIS_CLEAR)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (bus.s[i]),
            .r        (bus.r[i]),
            .en       (bus.en[i]),
            .clr_err  (bus.clr_err),
            .q        (w_q[i]),
            .rise     (bus.rise[i]),
            .fall     (bus.fall[i]),
            .conflict (bus.conflict[i]),
            .hit      (w_hit[i])
        );
    end

    assign w_any_hit = |w_hit;

    // One count per conflicting cycle; a clear in the same cycle restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.clr_err) begin
            r_cnt <= CNT_W'(w_any_hit);
        end else if (w_any_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.q            = w_q;
    assign bus.q_bar        = ~w_q;
    assign bus.conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sr_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_sr_reg_bank                                              |
// | Brief  : Directed bench over four MODE/DIS_CLEAR/CNT_W variants.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sr_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s, r, en;
    logic       clr_err;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    sr_reg_bank_if #(.WIDTH(8), .CNT_W(8)) b0 ();
    sr_reg_bank_if #(.WIDTH(8), .CNT_W(8)) b1 ();
    sr_reg_bank_if #(.WIDTH(8), .CNT_W(2)) b2 ();
    sr_reg_bank_if #(.WIDTH(8), .CNT_W(8)) b3 ();

    assign b0.s = s; assign b0.r = r; assign b0.en = en; assign b0.clr_err = clr_err;
    assign b1.s = s; assign b1.r = r; assign b1.en = en; assign b1.clr_err = clr_err;
    assign b2.s = s; assign b2.r = r; assign b2.en = en; assign b2.clr_err = clr_err;
    assign b3.s = s; assign b3.r = r; assign b3.en = en; assign b3.clr_err = clr_err;

    sr_reg_bank #(.WIDTH(8), .MODE(0), .DIS_CLEAR(1'b0), .CNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    sr_reg_bank #(.WIDTH(8), .MODE(1), .DIS_CLEAR(1'b1), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    sr_reg_bank #(.WIDTH(8), .MODE(2), .DIS_CLEAR(1'b0), .CNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    sr_reg_bank #(.WIDTH(8), .MODE(3), .DIS_CLEAR(1'b1), .CNT_W(8))
        u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    logic [3:0][7:0] qo, qbo, ro, fo, co, no;

    assign qo[0]  = b0.q;     assign qo[1]  = b1.q;     assign qo[2]  = b2.q;     assign qo[3]  = b3.q;
    assign qbo[0] = b0.q_bar; assign qbo[1] = b1.q_bar; assign qbo[2] = b2.q_bar; assign qbo[3] = b3.q_bar;
    assign ro[0]  = b0.rise;  assign ro[1]  = b1.rise;  assign ro[2]  = b2.rise;  assign ro[3]  = b3.rise;
    assign fo[0]  = b0.fall;  assign fo[1]  = b1.fall;  assign fo[2]  = b2.fall;  assign fo[3]  = b3.fall;
    assign co[0]  = b0.conflict; assign co[1] = b1.conflict;
    assign co[2]  = b2.conflict; assign co[3] = b3.conflict;
    assign no[0]  = b0.conflict_cnt; assign no[1] = b1.conflict_cnt;
    assign no[2]  = {6'd0, b2.conflict_cnt}; assign no[3] = b3.conflict_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed expectations are ordered {u3,u2,u1,u0}.
    task automatic chk_all(input string tag, input logic [31:0] q_e, input logic [31:0] rise_e,
                           input logic [31:0] fall_e, input logic [7:0] conf_e,
                           input logic [31:0] cnt_e);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.u%0d.q", tag, k),        qo[k],  q_e[k*8 +: 8]);
            chk($sformatf("%s.u%0d.q_bar", tag, k),    qbo[k], ~q_e[k*8 +: 8]);
            chk($sformatf("%s.u%0d.rise", tag, k),     ro[k],  rise_e[k*8 +: 8]);
            chk($sformatf("%s.u%0d.fall", tag, k),     fo[k],  fall_e[k*8 +: 8]);
            chk($sformatf("%s.u%0d.conflict", tag, k), co[k],  conf_e);
            chk($sformatf("%s.u%0d.cnt", tag, k),      no[k],  cnt_e[k*8 +: 8]);
        end
    endtask

    initial begin
        rst = 1'b1; s = 8'h00; r = 8'h00; en = 8'h00; clr_err = 1'b0;
        step(); chk_all("reset", 32'h0, 32'h0, 32'h0, 8'h00, 32'h0);

        rst = 1'b0; en = 8'hFF; s = 8'h01; r = 8'h00;
        step(); chk_all("set_ch0", 32'h01010101, 32'h01010101, 32'h0, 8'h00, 32'h0);
        s = 8'h00;
        step(); chk_all("hold_ch0", 32'h01010101, 32'h0, 32'h0, 8'h00, 32'h0);
        r = 8'h01;
        step(); chk_all("clr_ch0", 32'h0, 32'h0, 32'h01010101, 8'h00, 32'h0);

        s = 8'h04; r = 8'h04;
        step(); chk_all("conf1", 32'h04000004, 32'h04000004, 32'h0, 8'h04, 32'h01010101);
        step(); chk_all("conf2", 32'h00000004, 32'h0, 32'h04000000, 8'h04, 32'h02020202);
        step(); chk_all("conf3", 32'h04000004, 32'h04000000, 32'h0, 8'h04, 32'h03030303);

        r = 8'h00;
        step(); chk_all("preset2", 32'h04040404, 32'h00040400, 32'h0, 8'h04, 32'h03030303);
        r = 8'h04;
        step(); chk_all("conf_q1", 32'h00040004, 32'h0, 32'h04000400, 8'h04, 32'h04030404);

        s = 8'h02; r = 8'h00;
        step(); chk_all("set_ch1", 32'h02060206, 32'h02020202, 32'h0, 8'h04, 32'h04030404);
        en = 8'hFD; s = 8'h02; r = 8'h02;
        step(); chk_all("dis_ch1", 32'h00060006, 32'h0, 32'h02000200, 8'h04, 32'h04030404);

        en = 8'hFF; s = 8'h10; r = 8'h10; clr_err = 1'b1;
        step(); chk_all("clr_conf4", 32'h10060016, 32'h10000010, 32'h0, 8'h10, 32'h01010101);
        s = 8'h00; r = 8'h00;
        step(); chk_all("clr_idle", 32'h10060016, 32'h0, 32'h0, 8'h00, 32'h0);

        clr_err = 1'b0; s = 8'hFF; r = 8'h01;
        step(); chk_all("set_all", 32'hFFFEFEFF, 32'hEFF8FEE9, 32'h0, 8'h01, 32'h01010101);

        rst = 1'b1; s = 8'hFF; r = 8'h00; clr_err = 1'b1;
        step(); chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 8'h00, 32'h0);
        rst = 1'b0; clr_err = 1'b0;
        step(); chk_all("post_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8'h00, 32'h0);

        r = 8'hFF;
        step(); chk_all("conf_all", 32'h00FF00FF, 32'h0, 32'hFF00FF00, 8'hFF, 32'h01010101);
        en = 8'h00;
        step(); chk_all("dis_conf", 32'h00FF00FF, 32'h0, 32'h0, 8'hFF, 32'h01010101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
